// File: rtl/snitch_acc_pkg.sv
// snitch_acc_pkg: shared accelerator request/response types and id width
`ifndef SNITCH_ACC_TYPEDEFS
`define SNITCH_ACC_TYPEDEFS
`define SNITCH_ACC_TYPEDEF_REQ(name, dw, iw) \
  typedef struct packed { \
    logic [31:0]   addr; \
    logic [iw-1:0] id; \
    logic [31:0]   data_op; \
    logic [dw-1:0] data_arga; \
    logic [dw-1:0] data_argb; \
    logic [dw-1:0] data_argc; \
  } name;
`define SNITCH_ACC_TYPEDEF_RSP(name, dw, iw) \
  typedef struct packed { \
    logic [iw-1:0] id; \
    logic          error; \
    logic [dw-1:0] data; \
  } name;
`endif

package snitch_acc_pkg;
  localparam int IdWidth = 5;
  localparam int DefaultDataWidth = 32;
  `SNITCH_ACC_TYPEDEF_REQ(acc_req_t, DefaultDataWidth, IdWidth)
  `SNITCH_ACC_TYPEDEF_RSP(acc_rsp_t, DefaultDataWidth, IdWidth)
endpackage

// File: rtl/snitch_acc_scoreboard.sv
// snitch_acc_scoreboard: per-register busy bits with set/clear and 4-way lookup
module snitch_acc_scoreboard #(
  parameter int IdWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_i,
  input  logic [IdWidth-1:0]   set_id_i,
  input  logic                 clr_i,
  input  logic [IdWidth-1:0]   clr_id_i,
  output logic                 clr_hit_o,
  input  logic [4*IdWidth-1:0] look_id_i,
  output logic [3:0]           look_hit_o
);
  import snitch_acc_pkg::*;
  logic [2**IdWidth-1:0] sb;
  always_ff @(posedge clk_i) begin
    if (rst_i) sb <= '0;
    else begin
      if (clr_i) sb[clr_id_i] <= 1'b0;
      if (set_i) sb[set_id_i] <= 1'b1;
    end
  end
  assign clr_hit_o = sb[clr_id_i];
  for (genvar k = 0; k < 4; k++) begin : g_look
    assign look_hit_o[k] = sb[look_id_i[k*IdWidth +: IdWidth]];
  end
endmodule

// File: rtl/snitch_acc_initiator.sv
// snitch_acc_initiator: core-side accelerator offload initiator with scoreboard and writeback
module snitch_acc_initiator #(
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4,
  parameter int IdWidth        = snitch_acc_pkg::IdWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   off_valid_i,
  output logic                   off_ready_o,
  input  logic [31:0]            off_addr_i,
  input  logic [31:0]            off_op_i,
  input  logic [IdWidth-1:0]     off_rd_i,
  input  logic [3*IdWidth-1:0]   off_rs_i,
  input  logic [2:0]             off_rs_use_i,
  input  logic [DataWidth-1:0]   off_arga_i,
  input  logic [DataWidth-1:0]   off_argb_i,
  input  logic [DataWidth-1:0]   off_argc_i,
  output logic                   acc_qvalid_o,
  input  logic                   acc_qready_i,
  output logic [31:0]            acc_qaddr_o,
  output logic [IdWidth-1:0]     acc_qid_o,
  output logic [31:0]            acc_qdata_op_o,
  output logic [DataWidth-1:0]   acc_qdata_arga_o,
  output logic [DataWidth-1:0]   acc_qdata_argb_o,
  output logic [DataWidth-1:0]   acc_qdata_argc_o,
  input  logic                   acc_pvalid_i,
  output logic                   acc_pready_o,
  input  logic [IdWidth-1:0]     acc_pid_i,
  input  logic [DataWidth-1:0]   acc_pdata_i,
  input  logic                   acc_perror_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [IdWidth-1:0]     wb_rd_o,
  output logic [DataWidth-1:0]   wb_data_o,
  output logic                   busy_o,
  output logic                   err_o
);
  import snitch_acc_pkg::*;
  `SNITCH_ACC_TYPEDEF_REQ(req_t, DataWidth, IdWidth)
  localparam int CntW = $clog2(MaxOutstanding + 1);
  req_t                 q;
  logic                 q_valid, wb_valid, err;
  logic [IdWidth-1:0]   wb_rd;
  logic [DataWidth-1:0] wb_data;
  logic [CntW-1:0]      cnt;
  logic [3:0]           hit;
  logic                 pid_hit, hazard, issue, p_acc, p_known, dec, underflow;
  snitch_acc_scoreboard #(.IdWidth(IdWidth)) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (issue && off_rd_i != '0),
    .set_id_i   (off_rd_i),
    .clr_i      (dec),
    .clr_id_i   (acc_pid_i),
    .clr_hit_o  (pid_hit),
    .look_id_i  ({off_rd_i, off_rs_i}),
    .look_hit_o (hit)
  );
  assign hazard       = |(off_rs_use_i & hit[2:0]) || (off_rd_i != '0 && hit[3]);
  assign off_ready_o  = (!q_valid || acc_qready_i) && !hazard && cnt < CntW'(MaxOutstanding);
  assign issue        = off_valid_i && off_ready_o;
  assign acc_pready_o = !wb_valid || wb_ready_i;
  assign p_acc        = acc_pvalid_i && acc_pready_o;
  assign p_known      = acc_pid_i == '0 || pid_hit;
  assign dec          = p_acc && p_known;
  assign underflow    = dec && !issue && cnt == '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_valid  <= 1'b0;
      q        <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      if (issue) begin
        q_valid <= 1'b1;
        q       <= '{addr: off_addr_i, id: off_rd_i, data_op: off_op_i,
                     data_arga: off_arga_i, data_argb: off_argb_i, data_argc: off_argc_i};
      end else if (acc_qready_i) q_valid <= 1'b0;
      if (dec && acc_pid_i != '0) begin
        wb_valid <= 1'b1;
        wb_rd    <= acc_pid_i;
        wb_data  <= acc_pdata_i;
      end else if (wb_ready_i) wb_valid <= 1'b0;
      cnt <= issue && !dec ? cnt + CntW'(1) :
             dec && !issue && cnt != '0 ? cnt - CntW'(1) : cnt;
      if (underflow || (p_acc && (acc_perror_i || !p_known))) err <= 1'b1;
    end
  end
  assign acc_qvalid_o     = q_valid;
  assign acc_qaddr_o      = q.addr;
  assign acc_qid_o        = q.id;
  assign acc_qdata_op_o   = q.data_op;
  assign acc_qdata_arga_o = q.data_arga;
  assign acc_qdata_argb_o = q.data_argb;
  assign acc_qdata_argc_o = q.data_argc;
  assign wb_valid_o       = wb_valid;
  assign wb_rd_o          = wb_rd;
  assign wb_data_o        = wb_data;
  assign busy_o           = cnt != '0 || q_valid;
  assign err_o            = err;
  unmatched_rsp: assert property (@(posedge clk_i) disable iff (rst_i) !(p_acc && !p_known))
    else $warning("unmatched response id %0d dropped", acc_pid_i);
endmodule

// File: tb/tb_snitch_acc_initiator.sv
// tb_snitch_acc_initiator: table-driven hazard vectors plus scoreboarded request/writeback checks
module tb_snitch_acc_initiator;
  logic clk = 0, rst = 1;
  logic off_valid = 0, acc_qready = 1, acc_pvalid = 0, acc_perror = 0, wb_ready = 1;
  logic [31:0] off_addr = 0, off_op = 0, off_arga = 0, off_argb = 0, off_argc = 0, acc_pdata = 0;
  logic [4:0] off_rd = 0, acc_pid = 0;
  logic [14:0] off_rs = 0;
  logic [2:0] off_rs_use = 0;
  logic off_ready_o, acc_qvalid_o, acc_pready_o, wb_valid_o, busy_o, err_o;
  logic [31:0] acc_qaddr_o, acc_qdata_op_o, acc_qdata_arga_o, acc_qdata_argb_o, acc_qdata_argc_o, wb_data_o;
  logic [4:0] acc_qid_o, wb_rd_o;
  int errors = 0, checks = 0;
  typedef struct {logic [31:0] addr; logic [4:0] id; logic [31:0] op, a, b, c;} req_rec_t;
  typedef struct {logic [4:0] rd; logic [31:0] data;} wb_rec_t;
  typedef struct {logic [4:0] rd; logic [14:0] rs; logic [2:0] ru; logic exp;} hz_t;
  req_rec_t req_q[$];
  wb_rec_t wb_q[$];
  hz_t tbl[11];
  int m_cnt = 0;
  logic [31:0] m_sb = 0;
  bit m_qv = 0, m_err = 0;

  always #5 clk = ~clk;

  snitch_acc_initiator dut (
    .clk_i(clk), .rst_i(rst),
    .off_valid_i(off_valid), .off_ready_o(off_ready_o), .off_addr_i(off_addr), .off_op_i(off_op),
    .off_rd_i(off_rd), .off_rs_i(off_rs), .off_rs_use_i(off_rs_use),
    .off_arga_i(off_arga), .off_argb_i(off_argb), .off_argc_i(off_argc),
    .acc_qvalid_o(acc_qvalid_o), .acc_qready_i(acc_qready), .acc_qaddr_o(acc_qaddr_o),
    .acc_qid_o(acc_qid_o), .acc_qdata_op_o(acc_qdata_op_o), .acc_qdata_arga_o(acc_qdata_arga_o),
    .acc_qdata_argb_o(acc_qdata_argb_o), .acc_qdata_argc_o(acc_qdata_argc_o),
    .acc_pvalid_i(acc_pvalid), .acc_pready_o(acc_pready_o), .acc_pid_i(acc_pid),
    .acc_pdata_i(acc_pdata), .acc_perror_i(acc_perror),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  always @(negedge clk) begin : mon
    bit p, i, known;
    req_rec_t r;
    wb_rec_t w;
    if (rst) begin
      m_cnt = 0; m_sb = 0; m_qv = 0; m_err = 0;
      req_q.delete(); wb_q.delete();
    end else begin
      chk("err_o", err_o, m_err);
      chk("busy_o", busy_o, m_cnt != 0 || m_qv);
      if (acc_qvalid_o && acc_qready) begin
        if (req_q.size() == 0) fail("unexpected_request");
        else begin
          r = req_q.pop_front();
          chk("qaddr", acc_qaddr_o, r.addr); chk("qid", acc_qid_o, r.id);
          chk("qop", acc_qdata_op_o, r.op); chk("qarga", acc_qdata_arga_o, r.a);
          chk("qargb", acc_qdata_argb_o, r.b); chk("qargc", acc_qdata_argc_o, r.c);
        end
      end
      if (wb_valid_o && wb_ready) begin
        if (wb_q.size() == 0) fail("unexpected_writeback");
        else begin
          w = wb_q.pop_front();
          chk("wb_rd", wb_rd_o, w.rd); chk("wb_data", wb_data_o, w.data);
        end
      end
      p = acc_pvalid && acc_pready_o;
      i = off_valid && off_ready_o;
      known = acc_pid == 0 || m_sb[acc_pid];
      if (p) begin
        if (!known) m_err = 1;
        else begin
          m_sb[acc_pid] = 0;
          if (acc_pid != 0) wb_q.push_back('{acc_pid, acc_pdata});
          if (acc_perror) m_err = 1;
        end
      end
      if (i) begin
        req_q.push_back('{off_addr, off_rd, off_op, off_arga, off_argb, off_argc});
        if (off_rd != 0) m_sb[off_rd] = 1;
      end
      m_qv = i ? 1 : acc_qready ? 0 : m_qv;
      if (i && !(p && known)) m_cnt++;
      else if (p && known && !i) begin
        if (m_cnt == 0) m_err = 1;
        else m_cnt--;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_off(input logic [4:0] rd, input logic [14:0] rs, input logic [2:0] ru, input logic [31:0] a);
    off_rd = rd; off_rs = rs; off_rs_use = ru; off_arga = a;
    off_addr = 32'h1000_0000 | 32'(rd); off_op = 32'hABC0_0000 ^ a; off_argb = a + 1; off_argc = ~a;
  endtask

  task automatic offload(input logic [4:0] rd, input logic [14:0] rs, input logic [2:0] ru, input logic [31:0] a);
    int n = 0;
    drive_off(rd, rs, ru, a);
    off_valid = 1;
    #1;
    while (!off_ready_o && n < 50) begin tick(); n++; end
    if (n >= 50) fail("offload_timeout");
    tick();
    off_valid = 0;
  endtask

  task automatic respond(input logic [4:0] id, input logic [31:0] d, input logic e);
    int n = 0;
    acc_pvalid = 1; acc_pid = id; acc_pdata = d; acc_perror = e;
    #1;
    while (!acc_pready_o && n < 50) begin tick(); n++; end
    if (n >= 50) fail("respond_timeout");
    tick();
    acc_pvalid = 0; acc_perror = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{5'd1, 15'd0, 3'b000, 1'b1};
    tbl[1]  = '{5'd5, 15'd0, 3'b000, 1'b0};
    tbl[2]  = '{5'd7, 15'd0, 3'b000, 1'b0};
    tbl[3]  = '{5'd2, {5'd0, 5'd0, 5'd5}, 3'b001, 1'b0};
    tbl[4]  = '{5'd2, {5'd0, 5'd0, 5'd5}, 3'b000, 1'b1};
    tbl[5]  = '{5'd2, {5'd0, 5'd7, 5'd0}, 3'b010, 1'b0};
    tbl[6]  = '{5'd2, {5'd5, 5'd0, 5'd0}, 3'b100, 1'b0};
    tbl[7]  = '{5'd2, {5'd5, 5'd0, 5'd0}, 3'b011, 1'b1};
    tbl[8]  = '{5'd0, {5'd0, 5'd0, 5'd7}, 3'b000, 1'b1};
    tbl[9]  = '{5'd3, {5'd9, 5'd8, 5'd6}, 3'b111, 1'b1};
    tbl[10] = '{5'd0, {5'd0, 5'd5, 5'd0}, 3'b010, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_qvalid", acc_qvalid_o, 0); chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_err", err_o, 0); chk("rst_busy", busy_o, 0);
    chk("rst_qaddr", acc_qaddr_o, 0); chk("rst_qid", acc_qid_o, 0);
    chk("rst_off_ready", off_ready_o, 1); chk("rst_pready", acc_pready_o, 1);
    // single op
    offload(5, 0, 0, 7);
    chk("single_qvalid", acc_qvalid_o, 1); chk("single_qid", acc_qid_o, 5);
    off_rd = 5; #1;
    chk("single_sb5_set", off_ready_o, 0);
    respond(5, 32'h2A, 0);
    chk("single_wb_valid", wb_valid_o, 1); chk("single_wb_rd", wb_rd_o, 5); chk("single_wb_data", wb_data_o, 32'h2A);
    tick();
    chk("single_wb_done", wb_valid_o, 0); chk("single_idle", busy_o, 0);
    // RAW stall and one-cycle clear visibility
    offload(5, 0, 0, 32'h50);
    drive_off(8, {5'd0, 5'd0, 5'd5}, 3'b001, 32'h80);
    off_valid = 1; #1;
    chk("raw_stall0", off_ready_o, 0);
    tick();
    chk("raw_stall1", off_ready_o, 0);
    acc_pvalid = 1; acc_pid = 5; acc_pdata = 32'h55; #1;
    chk("raw_same_cycle", off_ready_o, 0);
    tick();
    acc_pvalid = 0;
    chk("raw_released", off_ready_o, 1);
    tick();
    off_valid = 0;
    respond(8, 32'h88, 0);
    // out-of-order responses
    offload(3, 0, 0, 3); offload(4, 0, 0, 4); offload(6, 0, 0, 6);
    respond(6, 32'h66, 0); respond(3, 32'h33, 0); respond(4, 32'h44, 0);
    tick(); tick();
    chk("ooo_idle", busy_o, 0);
    // outstanding limit and writeback backpressure
    offload(10, 0, 0, 10); offload(11, 0, 0, 11); offload(12, 0, 0, 12); offload(13, 0, 0, 13);
    drive_off(14, 0, 0, 14);
    off_valid = 1; #1;
    chk("limit_stall0", off_ready_o, 0);
    tick();
    chk("limit_stall1", off_ready_o, 0);
    off_valid = 0;
    wb_ready = 0;
    respond(10, 32'hA0, 0);
    chk("bp_wb_full", wb_valid_o, 1);
    acc_pvalid = 1; acc_pid = 11; acc_pdata = 32'hB0; #1;
    chk("bp_pready0", acc_pready_o, 0);
    tick();
    chk("bp_pready1", acc_pready_o, 0); chk("bp_wb_hold", wb_data_o, 32'hA0);
    wb_ready = 1; #1;
    chk("bp_pready_release", acc_pready_o, 1);
    tick();
    acc_pvalid = 0;
    respond(12, 32'hC0, 0); respond(13, 32'hD0, 0);
    tick(); tick();
    chk("limit_idle", busy_o, 0);
    // request register holds under backpressure
    acc_qready = 0;
    offload(20, 0, 0, 20);
    chk("qbp_valid0", acc_qvalid_o, 1); chk("qbp_id0", acc_qid_o, 20);
    off_rd = 21; #1;
    chk("qbp_slot_full", off_ready_o, 0);
    tick();
    chk("qbp_valid1", acc_qvalid_o, 1); chk("qbp_id1", acc_qid_o, 20);
    acc_qready = 1; #1;
    chk("qbp_slot_free", off_ready_o, 1);
    tick();
    respond(20, 32'h20, 0);
    // rd=0 result dropped
    offload(0, 0, 0, 32'hF0);
    respond(0, 32'hDEAD, 0);
    chk("rd0_no_wb", wb_valid_o, 0);
    tick();
    chk("rd0_idle", busy_o, 0);
    // perror still writes back
    offload(7, 0, 0, 7);
    respond(7, 32'h77, 1);
    chk("perr_err", err_o, 1); chk("perr_wb_valid", wb_valid_o, 1); chk("perr_wb_rd", wb_rd_o, 7);
    rst = 1; tick(); rst = 0;
    chk("perr_err_cleared", err_o, 0);
    // unmatched id
    respond(9, 32'h99, 0);
    chk("unmatched_err", err_o, 1); chk("unmatched_no_wb", wb_valid_o, 0);
    // reset mid-flight
    offload(3, 0, 0, 1); offload(4, 0, 0, 2); offload(5, 0, 0, 3);
    chk("mid_busy", busy_o, 1);
    rst = 1; tick(); rst = 0;
    chk("mid_qvalid", acc_qvalid_o, 0); chk("mid_busy_clr", busy_o, 0);
    chk("mid_err_clr", err_o, 0); chk("mid_wb_clr", wb_valid_o, 0);
    drive_off(3, {5'd5, 5'd0, 5'd4}, 3'b101, 0); #1;
    chk("mid_sb_clear", off_ready_o, 1);
    // hazard table with sb[5] and sb[7] set
    offload(5, 0, 0, 5); offload(7, 0, 0, 7);
    for (int k = 0; k < 11; k++) begin
      drive_off(tbl[k].rd, tbl[k].rs, tbl[k].ru, 0); #1;
      chk($sformatf("hazard_vec%0d", k), off_ready_o, tbl[k].exp);
    end
    respond(5, 32'h5, 0); respond(7, 32'h7, 0);
    tick(); tick();
    chk("final_idle", busy_o, 0);
    chk("req_q_drained", req_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
